load_store_unit: RTL and testbench
==================================

Name: load_store_unit

Overview:
- Memory-access stage directly downstream of the ALU. It consumes the ALU-computed effective address plus rs2 data and drives the RAM controller's word-wide load/store port.
- Performs RV32I LB/LH/LW/LBU/LHU/SB/SH/SW: alignment checks, lane extraction, sign/zero extension, and read-modify-write for sub-word stores (RAM has no byte enables).
- Asserts busy toward the PC stall path until the access completes. Returns the load result for register writeback.

Parameters:
- ADDR_W, 32, address width
- TIMEOUT_CYCLES, 255, max cycles waiting on mem_rd_valid/mem_wr_ready before bus trap (8-bit counter)

Ports:
- clk  input  1  system clock, rising edge
- reset  input  1  asynchronous, active-high
- start  input  1  one-cycle request pulse from execute; sampled only in IDLE
- is_store  input  1  1 = store, 0 = load
- funct3  input  3  000 B, 001 H, 010 W, 100 BU, 101 HU; others illegal
- addr  input  ADDR_W  effective address (ALU output)
- store_data  input  32  rs2 value
- busy  output  1  high from the cycle after an accepted start until the cycle done/trap pulses; drives stall
- done  output  1  one-cycle completion pulse
- load_result  output  32  extended load data; valid when done=1 on a load, held until next done
- misaligned_trap  output  1  one-cycle pulse: misaligned address or illegal funct3
- bus_trap  output  1  one-cycle pulse: timeout
- mem_addr  output  ADDR_W  word-aligned address ({addr[ADDR_W-1:2],2'b00})
- mem_rd_en  output  1  read request, level, held until mem_rd_valid
- mem_rd_data  input  32  read data
- mem_rd_valid  input  1  read data valid
- mem_wr_en  output  1  write request, level, held until mem_wr_ready
- mem_wr_data  output  32  full word to write
- mem_wr_ready  input  1  write accepted

Behaviour:
- Reset (async): state=IDLE. busy, done, misaligned_trap, bus_trap, mem_rd_en, mem_wr_en = 0. load_result, mem_addr, mem_wr_data = 0. Timeout counter = 0. Reset mid-access abandons it; no write is issued after reset deasserts.
- On an accepted start: latch addr, funct3, is_store, store_data, byte offset off=addr[1:0].
- Check:
  - H/HU with off[0]=1 → misaligned.
  - W with off≠0 → misaligned.
  - funct3 ∉ {000,001,010,100,101} → misaligned; funct3 100/101 with is_store → misaligned.
  - Misaligned → TRAP state, no memory request.
- States:
  - IDLE: start=1 → TRAP if misaligned; else WRITE if SW; else READ.
  - READ: mem_rd_en=1. On mem_rd_valid: load → DONE with extracted data; SB/SH → merge, then WRITE.
  - WRITE: mem_wr_en=1, mem_wr_data = store_data (SW) or merged word. On mem_wr_ready → DONE.
  - DONE: done=1 for one cycle → IDLE.
  - TRAP: trap pulse for one cycle, no done → IDLE.
- Extraction (little-endian):
  - Byte lane = data[8*off+7 : 8*off]; B sign-extends from bit 7, BU zero-extends.
  - Half lane = data[16*off[1]+15 : 16*off[1]]; H sign-extends, HU zero-extends.
- Merge: replace only the addressed byte/half lane of mem_rd_data with store_data[7:0]/[15:0]; other lanes unchanged.
- Handshake:
  - mem_rd_valid/mem_wr_ready outside READ/WRITE are ignored.
  - mem_rd_valid in the same cycle mem_rd_en first rises is accepted (zero-wait memory). Minimum latency: LW = 2 cycles start→done, SW = 2, SB/SH = 3 with zero-wait RAM.
- Timeout: counter clears on entering READ/WRITE and increments each waiting cycle. At TIMEOUT_CYCLES: drop request, go to TRAP with bus_trap.
- start while busy is ignored (no queueing).
- A trap produces no done, and load_result is not updated.

Test Plan:
- LW addr=0x100, RAM[0x100]=0xDEADBEEF, zero-wait → mem_addr=0x100, done 2 cycles after start, load_result=0xDEADBEEF, busy high 1 cycle.
- LB addr=0x103, word=0x80FF1234 → load_result=0xFFFFFF80. LBU same → 0x00000080. LHU addr=0x102 → 0x000080FF.
- SB addr=0x201, store_data=0xAA, RAM[0x200]=0x11223344 → one read, then write 0x1122AA44; done at cycle 3.
- LH addr=0x101 → misaligned_trap pulse 1 cycle after start; mem_rd_en/mem_wr_en never asserted; done stays 0. Same for SW addr=0x202 and funct3=011.
- TIMEOUT_CYCLES=4, LW with mem_rd_valid held 0 → bus_trap after 4 wait cycles, mem_rd_en drops, state IDLE.
- Assert reset while in WRITE with mem_wr_ready=0 → all outputs 0 immediately (async). After release, no mem_wr_en and busy=0 until the next start.

Source files
------------

// File: rtl/load_store_unit.sv
// RV32I memory-access stage: alignment checks, lane extraction and sign extension,
// and read-modify-write for sub-word stores on a RAM port without byte enables.
module load_store_unit #(
  parameter int ADDR_W         = 32,
  parameter int TIMEOUT_CYCLES = 255
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              start,
  input  logic              is_store,
  input  logic [2:0]        funct3,
  input  logic [ADDR_W-1:0] addr,
  input  logic [31:0]       store_data,
  output logic              busy,
  output logic              done,
  output logic [31:0]       load_result,
  output logic              misaligned_trap,
  output logic              bus_trap,
  output logic [ADDR_W-1:0] mem_addr,
  output logic              mem_rd_en,
  input  logic [31:0]       mem_rd_data,
  input  logic              mem_rd_valid,
  output logic              mem_wr_en,
  output logic [31:0]       mem_wr_data,
  input  logic              mem_wr_ready
);

  typedef enum logic [2:0] {S_IDLE, S_READ, S_WRITE, S_DONE, S_TRAP} state_t;

  localparam logic [7:0] TO_LAST = 8'(TIMEOUT_CYCLES - 1);

  state_t            r_state, w_state;
  logic [1:0]        r_off, w_off;
  logic [2:0]        r_funct3, w_funct3;
  logic              r_is_store, w_is_store;
  logic [31:0]       r_sdata, w_sdata;
  logic [7:0]        r_cnt, w_cnt;
  logic              r_busy, r_done, r_mis, r_bus, r_rd_en, r_wr_en;
  logic              w_done, w_mis, w_bus;
  logic [31:0]       r_load, w_load;
  logic [ADDR_W-1:0] r_maddr, w_maddr;
  logic [31:0]       r_wdata, w_wdata;

  function automatic logic f_misaligned(input logic [2:0] f3, input logic [1:0] off,
                                        input logic st);
    logic bad;
    case (f3)
      3'b000:  bad = 1'b0;
      3'b001:  bad = off[0];
      3'b010:  bad = (off != 2'b00);
      3'b100:  bad = st;
      3'b101:  bad = st | off[0];
      default: bad = 1'b1;
    endcase
    return bad;
  endfunction

  function automatic logic [31:0] f_extract(input logic [31:0] d, input logic [2:0] f3,
                                            input logic [1:0] off);
    logic [7:0]  b;
    logic [15:0] h;
    logic [31:0] r;
    b = d[{off, 3'b000} +: 8];
    h = d[{off[1], 4'b0000} +: 16];
    case (f3)
      3'b000:  r = {{24{b[7]}}, b};
      3'b001:  r = {{16{h[15]}}, h};
      3'b100:  r = {24'd0, b};
      3'b101:  r = {16'd0, h};
      default: r = d;
    endcase
    return r;
  endfunction

  // Only the addressed lane is replaced; the rest of the fetched word is written back as read.
  function automatic logic [31:0] f_merge(input logic [31:0] d, input logic [31:0] sd,
                                          input logic [2:0] f3, input logic [1:0] off);
    logic [31:0] r;
    r = d;
    case (f3)
      3'b000:  r[{off, 3'b000} +: 8] = sd[7:0];
      3'b001:  r[{off[1], 4'b0000} +: 16] = sd[15:0];
      default: r = sd;
    endcase
    return r;
  endfunction

  always_comb begin
    w_state    = r_state;
    w_off      = r_off;
    w_funct3   = r_funct3;
    w_is_store = r_is_store;
    w_sdata    = r_sdata;
    w_cnt      = r_cnt;
    w_done     = 1'b0;
    w_mis      = 1'b0;
    w_bus      = 1'b0;
    w_load     = r_load;
    w_maddr    = r_maddr;
    w_wdata    = r_wdata;
    case (r_state)
      S_IDLE: begin
        if (start) begin
          w_off      = addr[1:0];
          w_funct3   = funct3;
          w_is_store = is_store;
          w_sdata    = store_data;
          w_maddr    = {addr[ADDR_W-1:2], 2'b00};
          w_cnt      = 8'd0;
          if (f_misaligned(funct3, addr[1:0], is_store)) begin
            w_state = S_TRAP;
            w_mis   = 1'b1;
          end else if (is_store && (funct3 == 3'b010)) begin
            w_state = S_WRITE;
            w_wdata = store_data;
          end else begin
            w_state = S_READ;
          end
        end else begin
          w_state = S_IDLE;
        end
      end
      S_READ: begin
        if (mem_rd_valid) begin
          w_cnt = 8'd0;
          if (r_is_store) begin
            w_state = S_WRITE;
            w_wdata = f_merge(mem_rd_data, r_sdata, r_funct3, r_off);
          end else begin
            w_state = S_DONE;
            w_done  = 1'b1;
            w_load  = f_extract(mem_rd_data, r_funct3, r_off);
          end
        end else if (r_cnt == TO_LAST) begin
          w_state = S_TRAP;
          w_bus   = 1'b1;
        end else begin
          w_cnt = r_cnt + 8'd1;
        end
      end
      S_WRITE: begin
        if (mem_wr_ready) begin
          w_state = S_DONE;
          w_done  = 1'b1;
        end else if (r_cnt == TO_LAST) begin
          w_state = S_TRAP;
          w_bus   = 1'b1;
        end else begin
          w_cnt = r_cnt + 8'd1;
        end
      end
      S_DONE:  w_state = S_IDLE;
      S_TRAP:  w_state = S_IDLE;
      default: w_state = S_IDLE;
    endcase
  end

  // Outputs are registered against the next state so request lines never glitch.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_state    <= S_IDLE;
      r_off      <= 2'd0;
      r_funct3   <= 3'd0;
      r_is_store <= 1'b0;
      r_sdata    <= 32'd0;
      r_cnt      <= 8'd0;
      r_busy     <= 1'b0;
      r_done     <= 1'b0;
      r_mis      <= 1'b0;
      r_bus      <= 1'b0;
      r_rd_en    <= 1'b0;
      r_wr_en    <= 1'b0;
      r_load     <= 32'd0;
      r_maddr    <= '0;
      r_wdata    <= 32'd0;
    end else begin
      r_state    <= w_state;
      r_off      <= w_off;
      r_funct3   <= w_funct3;
      r_is_store <= w_is_store;
      r_sdata    <= w_sdata;
      r_cnt      <= w_cnt;
      r_busy     <= (w_state == S_READ) || (w_state == S_WRITE);
      r_done     <= w_done;
      r_mis      <= w_mis;
      r_bus      <= w_bus;
      r_rd_en    <= (w_state == S_READ);
      r_wr_en    <= (w_state == S_WRITE);
      r_load     <= w_load;
      r_maddr    <= w_maddr;
      r_wdata    <= w_wdata;
    end
  end

  assign busy            = r_busy;
  assign done            = r_done;
  assign load_result     = r_load;
  assign misaligned_trap = r_mis;
  assign bus_trap        = r_bus;
  assign mem_addr        = r_maddr;
  assign mem_rd_en       = r_rd_en;
  assign mem_wr_en       = r_wr_en;
  assign mem_wr_data     = r_wdata;

endmodule

// File: tb/tb_load_store_unit.sv
// Directed bench for load_store_unit against a single-word RAM stub with
// switchable zero-wait or stalled handshakes.
module tb_load_store_unit;

  logic        clk = 1'b0;
  logic        reset;
  logic        start;
  logic        is_store;
  logic [2:0]  funct3;
  logic [31:0] addr;
  logic [31:0] store_data;
  logic        busy, done, misaligned_trap, bus_trap;
  logic [31:0] load_result, mem_addr, mem_wr_data;
  logic        mem_rd_en, mem_wr_en;
  logic [31:0] mem_rd_data;
  logic        mem_rd_valid, mem_wr_ready;

  logic [31:0] ram_word;
  logic        rd_auto, wr_auto;
  int          rd_hs, wr_hs, rd_seen, wr_seen;
  logic [31:0] last_wr;
  int          total = 0;
  int          bad = 0;
  int          cyc, busy_cyc;

  always #5 clk = ~clk;

  assign mem_rd_data  = ram_word;
  assign mem_rd_valid = mem_rd_en & rd_auto;
  assign mem_wr_ready = mem_wr_en & wr_auto;

  load_store_unit #(.ADDR_W(32), .TIMEOUT_CYCLES(4)) dut (
    .clk(clk), .reset(reset), .start(start), .is_store(is_store), .funct3(funct3),
    .addr(addr), .store_data(store_data), .busy(busy), .done(done),
    .load_result(load_result), .misaligned_trap(misaligned_trap), .bus_trap(bus_trap),
    .mem_addr(mem_addr), .mem_rd_en(mem_rd_en), .mem_rd_data(mem_rd_data),
    .mem_rd_valid(mem_rd_valid), .mem_wr_en(mem_wr_en), .mem_wr_data(mem_wr_data),
    .mem_wr_ready(mem_wr_ready)
  );

  always @(posedge clk) begin
    if (mem_rd_en) rd_seen = rd_seen + 1;
    if (mem_wr_en) wr_seen = wr_seen + 1;
    if (mem_rd_en && mem_rd_valid) rd_hs = rd_hs + 1;
    if (mem_wr_en && mem_wr_ready) begin
      wr_hs   = wr_hs + 1;
      last_wr = mem_wr_data;
    end
  end

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    if (obs !== exp) begin
      bad++;
      $display("FAIL %s: got 0x%08h want 0x%08h", tag, obs, exp);
    end
  endtask

  task automatic run(input logic st, input logic [2:0] f3, input logic [31:0] a,
                     input logic [31:0] sd, output int n_cyc, output int n_busy);
    rd_hs = 0; wr_hs = 0; rd_seen = 0; wr_seen = 0;
    @(negedge clk);
    is_store = st; funct3 = f3; addr = a; store_data = sd; start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    n_cyc = 1; n_busy = 0;
    while (!(done || misaligned_trap || bus_trap) && n_cyc < 30) begin
      if (busy) n_busy++;
      @(negedge clk);
      n_cyc++;
    end
    if (n_cyc >= 30) check("no_completion", 32'd0, 32'd1);
  endtask

  initial begin
    reset = 1'b1; start = 1'b0; is_store = 1'b0; funct3 = 3'b000;
    addr = 32'd0; store_data = 32'd0; ram_word = 32'd0;
    rd_auto = 1'b1; wr_auto = 1'b1;
    rd_hs = 0; wr_hs = 0; rd_seen = 0; wr_seen = 0; last_wr = 32'd0;
    repeat (2) @(negedge clk);
    check("rst_busy", {31'd0, busy}, 32'd0);
    check("rst_done", {31'd0, done}, 32'd0);
    check("rst_en", {30'd0, mem_rd_en, mem_wr_en}, 32'd0);
    check("rst_load", load_result, 32'd0);
    check("rst_addr", mem_addr, 32'd0);
    reset = 1'b0;

    ram_word = 32'hDEADBEEF;
    run(1'b0, 3'b010, 32'h100, 32'd0, cyc, busy_cyc);
    check("lw_cyc", cyc, 32'd2);
    check("lw_done", {31'd0, done}, 32'd1);
    check("lw_data", load_result, 32'hDEADBEEF);
    check("lw_addr", mem_addr, 32'h100);
    check("lw_busy", busy_cyc, 32'd1);
    check("lw_busy_at_done", {31'd0, busy}, 32'd0);
    @(negedge clk);
    check("lw_done_pulse", {31'd0, done}, 32'd0);
    check("lw_load_held", load_result, 32'hDEADBEEF);

    ram_word = 32'h80FF1234;
    run(1'b0, 3'b000, 32'h103, 32'd0, cyc, busy_cyc);
    check("lb_data", load_result, 32'hFFFFFF80);
    run(1'b0, 3'b100, 32'h103, 32'd0, cyc, busy_cyc);
    check("lbu_data", load_result, 32'h00000080);
    run(1'b0, 3'b101, 32'h102, 32'd0, cyc, busy_cyc);
    check("lhu_data", load_result, 32'h000080FF);
    run(1'b0, 3'b001, 32'h102, 32'd0, cyc, busy_cyc);
    check("lh_data", load_result, 32'hFFFF80FF);
    run(1'b0, 3'b000, 32'h100, 32'd0, cyc, busy_cyc);
    check("lb0_data", load_result, 32'h00000034);
    check("lb0_addr", mem_addr, 32'h100);

    ram_word = 32'h11223344;
    run(1'b1, 3'b000, 32'h201, 32'h000000AA, cyc, busy_cyc);
    check("sb_cyc", cyc, 32'd3);
    check("sb_rd", rd_hs, 32'd1);
    check("sb_wr", wr_hs, 32'd1);
    check("sb_data", last_wr, 32'h1122AA44);
    check("sb_addr", mem_addr, 32'h200);
    check("sb_load_kept", load_result, 32'h00000034);
    run(1'b1, 3'b001, 32'h202, 32'h1234BEEF, cyc, busy_cyc);
    check("sh_data", last_wr, 32'hBEEF3344);
    run(1'b1, 3'b010, 32'h300, 32'hCAFEF00D, cyc, busy_cyc);
    check("sw_cyc", cyc, 32'd2);
    check("sw_rd", rd_seen, 32'd0);
    check("sw_data", last_wr, 32'hCAFEF00D);

    for (int i = 0; i < 4; i++) begin
      logic        st;
      logic [2:0]  f3;
      logic [31:0] a;
      case (i)
        0:       begin st = 1'b0; f3 = 3'b001; a = 32'h101; end
        1:       begin st = 1'b1; f3 = 3'b010; a = 32'h202; end
        2:       begin st = 1'b0; f3 = 3'b011; a = 32'h100; end
        default: begin st = 1'b1; f3 = 3'b100; a = 32'h100; end
      endcase
      run(st, f3, a, 32'h55, cyc, busy_cyc);
      check($sformatf("mis%0d_cyc", i), cyc, 32'd1);
      check($sformatf("mis%0d_flags", i), {29'd0, misaligned_trap, bus_trap, done}, 32'd4);
      check($sformatf("mis%0d_mem", i), rd_seen + wr_seen, 32'd0);
      check($sformatf("mis%0d_load", i), load_result, 32'h00000034);
      @(negedge clk);
      check($sformatf("mis%0d_pulse", i), {31'd0, misaligned_trap}, 32'd0);
    end

    rd_auto = 1'b0;
    run(1'b0, 3'b010, 32'h100, 32'd0, cyc, busy_cyc);
    check("to_cyc", cyc, 32'd5);
    check("to_flags", {29'd0, misaligned_trap, bus_trap, done}, 32'd2);
    check("to_wait", busy_cyc, 32'd4);
    check("to_rd_en", {31'd0, mem_rd_en}, 32'd0);
    check("to_load", load_result, 32'h00000034);
    rd_auto = 1'b1;
    @(negedge clk);
    check("to_idle_busy", {31'd0, busy}, 32'd0);

    wr_auto = 1'b0;
    @(negedge clk);
    is_store = 1'b1; funct3 = 3'b010; addr = 32'h400; store_data = 32'h12345678; start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    check("rw_pre_wr_en", {31'd0, mem_wr_en}, 32'd1);
    #2 reset = 1'b1;
    #1;
    check("rw_async_en", {30'd0, mem_rd_en, mem_wr_en}, 32'd0);
    check("rw_async_busy", {31'd0, busy}, 32'd0);
    check("rw_async_addr", mem_addr, 32'd0);
    check("rw_async_wdata", mem_wr_data, 32'd0);
    check("rw_async_load", load_result, 32'd0);
    @(negedge clk);
    reset = 1'b0;
    wr_seen = 0;
    wr_auto = 1'b1;
    repeat (4) @(negedge clk);
    check("rw_no_write", wr_seen, 32'd0);
    check("rw_idle_busy", {31'd0, busy}, 32'd0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
